dot_prod_sched: RTL and testbench
=================================

# dot_prod_sched

Lag-sweep scheduler for the `dot_prod` datapath in the CAF engine.
- On `start`, steps a lag index from 0 to `num_lags-1`.
- For each lag, issues one dot-product request and waits for the product.
- Forwards each (lag, i, q) result downstream over a valid/ready handshake.
- Optionally tracks the peak-magnitude lag.
- Sits between the sample-window buffer (addressed by `lag_addr`) and the CAF result writer.

## Interface
Parameters:
- `num_lags`, 16 — lags per sweep, ≥1.
- `lag_bits`, 8 — width of lag fields; 2^`lag_bits` ≥ `num_lags`.
- `i_bits`, 24 — width of dot-product I result.
- `q_bits`, 24 — width of dot-product Q result; must be ≤ `i_bits`.
- `timeout`, 64 — max WAIT cycles before abort, ≥2.

Ports:
- `clk` in 1 — clock; all logic on the rising edge.
- `rst_n` in 1 — reset, asynchronous, active-low.
- `start` in 1 — sweep request, sampled in IDLE only.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — one-cycle pulse at sweep end (normal or abort).
- `error` out 1 — sticky timeout flag; cleared by the next accepted `start`.
- `lag_addr` out `lag_bits` — current lag to the window buffer.
- `dp_in_tvalid` out 1 — drives `dot_prod` x/y tvalid.
- `dp_product_tready` out 1 — drives `dot_prod` product tready.
- `dp_out_tvalid` in 1 — product valid from `dot_prod`.
- `dp_i` in `i_bits` (signed) — product I.
- `dp_q` in `q_bits` (signed) — product Q.
- `res_tvalid` out 1 — result valid.
- `res_tready` in 1 — result ready.
- `res_lag` out `lag_bits` — result lag.
- `res_i` out `i_bits` — result I.
- `res_q` out `q_bits` — result Q.
- `peak_lag` out `lag_bits` — lag of max magnitude.
- `peak_mag` out `i_bits+1` — max |i|+|q|.

## Operation
States: IDLE, ISSUE, WAIT, EMIT, DONE.
- IDLE
  - `start`=1: clear `lag_addr`, `error` and the peak registers; go to ISSUE.
- ISSUE
  - `dp_in_tvalid`=1 for exactly one cycle; go to WAIT.
  - Reset the wait counter to 0.
- WAIT
  - `dp_product_tready`=1; the wait counter increments each cycle.
  - `dp_out_tvalid`=1: capture `dp_i`/`dp_q`/`lag_addr` into the `res_*` registers; go to EMIT.
  - Counter reaches `timeout-1` with no `dp_out_tvalid`: set `error`; go to DONE with no result emitted.
  - `dp_out_tvalid` outside WAIT is ignored.
- EMIT
  - `res_tvalid`=1; `res_*` are held stable until `res_tready`.
  - On handshake, if `lag_addr`==`num_lags-1`, go to DONE; otherwise increment `lag_addr` and go to ISSUE.
- DONE
  - `done`=1 for one cycle; go to IDLE.
  - `lag_addr` keeps its last value.
- Magnitude `m = |dp_i| + |dp_q|`:
  - Computed unsigned at `i_bits+1` bits with no overflow.
  - |−2^(n−1)| = 2^(n−1).
- Peak update at WAIT capture:
  - If `m > peak_mag` (strictly greater), load `peak_mag`/`peak_lag`.
  - On ties the lowest lag wins.
- `start` while `busy` is ignored.
- Aborted sweeps keep the peak registers as of the last completed lag.

## Timing
- Reset values: all outputs 0, state IDLE.
  - Reset mid-sweep returns to IDLE immediately, with no `done` pulse.
- `start` at edge N → `busy`=1 and ISSUE at N+1.
  - `dp_in_tvalid` is high during cycle N+1 only.
- `dp_out_tvalid` sampled high at edge M in WAIT → `res_tvalid`=1 after edge M.
- Minimum per-lag cost: 1 (ISSUE) + dot_prod latency (WAIT) + 1 (EMIT, with `res_tready`=1).
- `done` is asserted the cycle after the final EMIT handshake or the timeout; `busy` drops with the `done` cycle's successor.
- `res_tvalid` never deasserts without a handshake.
- `peak_*` are valid once `done` is seen.

## Configuration
- `DOT_PROD_SCHED_PEAK_EN`:
  - Defined: magnitude and peak logic present as described.
  - Undefined: no magnitude logic is synthesised; `peak_lag` and `peak_mag` are tied to 0.
  - All other behaviour is identical in both builds.

## Test plan
- Bench model: `dot_prod` with 3-cycle latency returning i=lag·10, q=−lag, `num_lags`=4, `res_tready`=1.
  - Expect 4 results, lags 0..3 in order, each cycle = 1+3+1 = 5 cycles.
  - Expect a `done` pulse, `peak_lag`=3, `peak_mag`=33.
- Ties: model returns i=5, q=−5 for every lag → `peak_lag`=0, `peak_mag`=10.
- Backpressure: `res_tready` low 7 cycles at lag 1.
  - `res_*` stable throughout the stall.
  - No `dp_in_tvalid` until the handshake; no result lost or duplicated.
- Timeout: model never responds at lag 2, `timeout`=64.
  - `error`=1 and `done` 64 cycles after WAIT entry.
  - Only lags 0–1 emitted.
  - Next `start` clears `error`.
- Reset and `start` robustness:
  - `rst_n` low mid-WAIT → all outputs 0 immediately; no `done`.
  - `start` pulses while `busy` are ignored.
- Extreme values: i=−2^23, q=−2^23 → `peak_mag`=2^24.
  - Macro undefined → `peak_*` remain 0.

Source files
------------

// File: rtl/dot_prod_sched.sv
// dot_prod_sched: lag-sweep scheduler for dot_prod; peak tracking under `DOT_PROD_SCHED_PEAK_EN
module dot_prod_sched #(
  parameter int num_lags = 16,
  parameter int lag_bits = 8,
  parameter int i_bits   = 24,
  parameter int q_bits   = 24,
  parameter int timeout  = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     error,
  output logic [lag_bits-1:0]      lag_addr,
  output logic                     dp_in_tvalid,
  output logic                     dp_product_tready,
  input  logic                     dp_out_tvalid,
  input  logic signed [i_bits-1:0] dp_i,
  input  logic signed [q_bits-1:0] dp_q,
  output logic                     res_tvalid,
  input  logic                     res_tready,
  output logic [lag_bits-1:0]      res_lag,
  output logic [i_bits-1:0]        res_i,
  output logic [q_bits-1:0]        res_q,
  output logic [lag_bits-1:0]      peak_lag,
  output logic [i_bits:0]          peak_mag
);
  localparam int cw = $clog2(timeout);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, EMIT, DONE} state_t;
  state_t state;
  logic [cw-1:0] wcnt;
  // sweep sequencer with all handshake and status outputs registered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      busy              <= 1'b0;
      done              <= 1'b0;
      error             <= 1'b0;
      lag_addr          <= '0;
      dp_in_tvalid      <= 1'b0;
      dp_product_tready <= 1'b0;
      res_tvalid        <= 1'b0;
      res_lag           <= '0;
      res_i             <= '0;
      res_q             <= '0;
      wcnt              <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state        <= ISSUE;
          busy         <= 1'b1;
          error        <= 1'b0;
          lag_addr     <= '0;
          dp_in_tvalid <= 1'b1;
        end
        ISSUE: begin
          state             <= WAIT;
          dp_in_tvalid      <= 1'b0;
          dp_product_tready <= 1'b1;
          wcnt              <= '0;
        end
        WAIT: if (dp_out_tvalid) begin
          state             <= EMIT;
          dp_product_tready <= 1'b0;
          res_tvalid        <= 1'b1;
          res_lag           <= lag_addr;
          res_i             <= dp_i;
          res_q             <= dp_q;
        end else if (wcnt == cw'(timeout - 1)) begin
          state             <= DONE;
          dp_product_tready <= 1'b0;
          error             <= 1'b1;
          done              <= 1'b1;
        end else begin
          wcnt <= wcnt + cw'(1);
        end
        EMIT: if (res_tready) begin
          res_tvalid <= 1'b0;
          if (lag_addr == lag_bits'(num_lags - 1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state        <= ISSUE;
            lag_addr     <= lag_addr + lag_bits'(1);
            dp_in_tvalid <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef DOT_PROD_SCHED_PEAK_EN
  logic [i_bits-1:0] abs_i;
  logic [q_bits-1:0] abs_q;
  logic [i_bits:0]   mag;
  // |x| as unsigned so the most negative value maps to 2^(n-1); sum cannot overflow
  always_comb begin
    abs_i = dp_i[i_bits-1] ? $unsigned(-dp_i) : $unsigned(dp_i);
    abs_q = dp_q[q_bits-1] ? $unsigned(-dp_q) : $unsigned(dp_q);
    mag   = {1'b0, abs_i} + (i_bits + 1)'(abs_q);
  end
  // strictly-greater update on capture keeps the lowest lag on ties
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak_lag <= '0;
      peak_mag <= '0;
    end else if (state == IDLE && start) begin
      peak_lag <= '0;
      peak_mag <= '0;
    end else if (state == WAIT && dp_out_tvalid && mag > peak_mag) begin
      peak_lag <= lag_addr;
      peak_mag <= mag;
    end
  end
`else
  assign peak_lag = '0;
  assign peak_mag = '0;
`endif
endmodule

// File: tb/tb_dot_prod_sched.sv
// tb_dot_prod_sched: randomized sweeps against a behavioural dot_prod and result model
module tb_dot_prod_sched;
  localparam int NL = 4;
  localparam int TO = 64;
  logic clk = 0, rst_n = 1, start = 0;
  logic busy, done, error, dp_in_tvalid, dp_product_tready, res_tvalid;
  logic dp_out_tvalid = 0, res_tready = 1;
  logic [7:0] lag_addr, res_lag, peak_lag;
  logic signed [23:0] dp_i = '0, dp_q = '0;
  logic [23:0] res_i, res_q;
  logic [24:0] peak_mag;
  int tests = 0, fails = 0, cyc = 0;
  logic signed [23:0] mod_i [NL];
  logic signed [23:0] mod_q [NL];
  int noresp_lag = -1, pend = 0, plag = 0, stall_lag = -1, stall_left = 0;
  int done_cnt = 0, done_cyc = 0, issue_cnt = 0;
  int issue_cyc [NL];
  bit unstable = 0, pv = 0, pr = 0;
  logic [7:0] pl_r;
  logic [23:0] pi_r, pq_r;
  int h_lag[$], h_cyc[$];
  logic [23:0] h_i[$], h_q[$];

  dot_prod_sched #(.num_lags(NL), .lag_bits(8), .i_bits(24), .q_bits(24), .timeout(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done), .error(error),
    .lag_addr(lag_addr), .dp_in_tvalid(dp_in_tvalid), .dp_product_tready(dp_product_tready),
    .dp_out_tvalid(dp_out_tvalid), .dp_i(dp_i), .dp_q(dp_q), .res_tvalid(res_tvalid),
    .res_tready(res_tready), .res_lag(res_lag), .res_i(res_i), .res_q(res_q),
    .peak_lag(peak_lag), .peak_mag(peak_mag));

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // dot_prod stand-in: product valid sampled 3 edges after the request edge
  always @(negedge clk) begin
    dp_out_tvalid = 0;
    if (!rst_n) pend = 0;
    else begin
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin dp_out_tvalid = 1; dp_i = mod_i[plag]; dp_q = mod_q[plag]; end
      end
      if (dp_in_tvalid && int'(lag_addr) != noresp_lag) begin pend = 3; plag = int'(lag_addr); end
    end
  end

  // result sink, stall injection and event recording
  always @(negedge clk) begin
    if (pv && !pr && (!res_tvalid || res_lag !== pl_r || res_i !== pi_r || res_q !== pq_r)) unstable = 1;
    if (res_tvalid && int'(res_lag) == stall_lag && stall_left > 0) begin res_tready = 0; stall_left--; end
    else res_tready = 1;
    if (res_tvalid && res_tready) begin
      h_lag.push_back(int'(res_lag)); h_i.push_back(res_i); h_q.push_back(res_q); h_cyc.push_back(cyc);
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (dp_in_tvalid) begin issue_cnt++; issue_cyc[int'(lag_addr) % NL] = cyc; end
    pv = res_tvalid; pr = res_tready; pl_r = res_lag; pi_r = res_i; pq_r = res_q;
  end

  function automatic longint mag(input logic signed [23:0] a, input logic signed [23:0] b);
    longint x = a, y = b;
    return (x < 0 ? -x : x) + (y < 0 ? -y : y);
  endfunction

  // peak of the first n completed lags; strict > keeps lowest lag on ties
  function automatic void exp_peak(input int n, output int pl, output longint pm);
    pl = 0; pm = 0;
    for (int k = 0; k < n; k++) if (mag(mod_i[k], mod_q[k]) > pm) begin pm = mag(mod_i[k], mod_q[k]); pl = k; end
`ifndef DOT_PROD_SCHED_PEAK_EN
    pl = 0; pm = 0;
`endif
  endfunction

  task automatic fill_rand();
    for (int k = 0; k < NL; k++) begin mod_i[k] = 24'($urandom); mod_q[k] = 24'($urandom); end
  endtask

  task automatic fill_lin();
    for (int k = 0; k < NL; k++) begin mod_i[k] = 24'(k * 10); mod_q[k] = 24'(-k); end
  endtask

  task automatic clear_obs();
    h_lag.delete(); h_i.delete(); h_q.delete(); h_cyc.delete();
    done_cnt = 0; issue_cnt = 0; unstable = 0;
  endtask

  task automatic run_sweep(output bit ok);
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int c = 0; c < 2000 && done_cnt == 0; c++) @(negedge clk);
    ok = done_cnt > 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst_n = 0;
    #1 tests++;
    if ({busy, done, error, lag_addr, dp_in_tvalid, dp_product_tready, res_tvalid, res_lag, res_i, res_q, peak_lag, peak_mag} !== '0) begin
      fails++; $display("FAIL reset_outputs busy=%b res_tvalid=%b lag=%0d peak_mag=%0d want all 0", busy, res_tvalid, lag_addr, peak_mag);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, done, res_tvalid, dp_in_tvalid} !== 4'b0) begin fails++; $display("FAIL reset_idle busy=%b done=%b want 0", busy, done); end
  endtask

  task automatic test_basic();
    bit ok; int pl; longint pm;
    fill_lin(); clear_obs(); run_sweep(ok); exp_peak(NL, pl, pm);
    tests++; if (!ok) begin fails++; $display("FAIL basic_done no done pulse within bound"); end
    tests++; if (h_lag.size() != NL) begin fails++; $display("FAIL basic_count got %0d want %0d", h_lag.size(), NL); end
    for (int k = 0; k < h_lag.size() && k < NL; k++) begin
      tests++;
      if (h_lag[k] !== k || h_i[k] !== mod_i[k] || h_q[k] !== mod_q[k]) begin
        fails++; $display("FAIL basic_res%0d got %0d/%0h/%0h want %0d/%0h/%0h", k, h_lag[k], h_i[k], h_q[k], k, mod_i[k], mod_q[k]);
      end
    end
    for (int k = 1; k < h_cyc.size(); k++) begin
      tests++; if (h_cyc[k] - h_cyc[k-1] !== 5) begin fails++; $display("FAIL basic_spacing%0d got %0d want 5", k, h_cyc[k] - h_cyc[k-1]); end
    end
    tests++; if (done_cnt !== 1 || issue_cnt !== NL) begin fails++; $display("FAIL basic_pulses done=%0d issue=%0d want 1/%0d", done_cnt, issue_cnt, NL); end
    tests++; if ({busy, error} !== 2'b00) begin fails++; $display("FAIL basic_status busy=%b error=%b want 0/0", busy, error); end
    tests++; if (int'(peak_lag) !== pl || longint'(peak_mag) !== pm) begin fails++; $display("FAIL basic_peak got %0d/%0d want %0d/%0d", peak_lag, peak_mag, pl, pm); end
  endtask

  task automatic test_ties();
    bit ok; int pl; longint pm;
    for (int k = 0; k < NL; k++) begin mod_i[k] = 24'sd5; mod_q[k] = -24'sd5; end
    clear_obs(); run_sweep(ok); exp_peak(NL, pl, pm);
    tests++; if (!ok || h_lag.size() != NL) begin fails++; $display("FAIL ties_sweep done=%0d results=%0d want 1/%0d", done_cnt, h_lag.size(), NL); end
    tests++; if (int'(peak_lag) !== pl || longint'(peak_mag) !== pm) begin fails++; $display("FAIL ties_peak got %0d/%0d want %0d/%0d", peak_lag, peak_mag, pl, pm); end
  endtask

  task automatic test_backpressure();
    bit ok; int pl; longint pm;
    fill_rand(); clear_obs(); stall_lag = 1; stall_left = 7;
    run_sweep(ok); stall_lag = -1; exp_peak(NL, pl, pm);
    tests++; if (!ok || h_lag.size() != NL) begin fails++; $display("FAIL bp_count done=%0d results=%0d want 1/%0d", done_cnt, h_lag.size(), NL); end
    for (int k = 0; k < h_lag.size() && k < NL; k++) begin
      tests++;
      if (h_lag[k] !== k || h_i[k] !== mod_i[k] || h_q[k] !== mod_q[k]) begin
        fails++; $display("FAIL bp_res%0d got %0d/%0h/%0h want %0d/%0h/%0h", k, h_lag[k], h_i[k], h_q[k], k, mod_i[k], mod_q[k]);
      end
    end
    tests++; if (unstable || stall_left !== 0) begin fails++; $display("FAIL bp_stable unstable=%0d stall_left=%0d want 0/0", unstable, stall_left); end
    tests++; if (issue_cnt !== NL) begin fails++; $display("FAIL bp_issues got %0d want %0d", issue_cnt, NL); end
    if (h_cyc.size() >= 3) begin
      tests++;
      if (h_cyc[1] - h_cyc[0] !== 12 || h_cyc[2] - h_cyc[1] !== 5) begin
        fails++; $display("FAIL bp_timing gaps %0d/%0d want 12/5", h_cyc[1] - h_cyc[0], h_cyc[2] - h_cyc[1]);
      end
    end
    tests++; if (int'(peak_lag) !== pl || longint'(peak_mag) !== pm) begin fails++; $display("FAIL bp_peak got %0d/%0d want %0d/%0d", peak_lag, peak_mag, pl, pm); end
  endtask

  task automatic test_timeout();
    bit ok; int pl; longint pm;
    fill_lin(); clear_obs(); noresp_lag = 2;
    run_sweep(ok); noresp_lag = -1; exp_peak(2, pl, pm);
    tests++; if (!ok || error !== 1'b1) begin fails++; $display("FAIL to_error done=%0d error=%b want 1/1", done_cnt, error); end
    tests++; if (h_lag.size() != 2) begin fails++; $display("FAIL to_count got %0d want 2", h_lag.size()); end
    for (int k = 0; k < h_lag.size() && k < 2; k++) begin
      tests++; if (h_lag[k] !== k || h_i[k] !== mod_i[k]) begin fails++; $display("FAIL to_res%0d got %0d/%0h want %0d/%0h", k, h_lag[k], h_i[k], k, mod_i[k]); end
    end
    tests++; if (done_cyc - issue_cyc[2] !== TO + 1) begin fails++; $display("FAIL to_latency got %0d want %0d", done_cyc - issue_cyc[2], TO + 1); end
    tests++; if (int'(peak_lag) !== pl || longint'(peak_mag) !== pm) begin fails++; $display("FAIL to_peak got %0d/%0d want %0d/%0d", peak_lag, peak_mag, pl, pm); end
    clear_obs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    tests++; if (error !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL to_clear error=%b busy=%b want 0/1", error, busy); end
    for (int c = 0; c < 2000 && done_cnt == 0; c++) @(negedge clk);
    repeat (2) @(negedge clk);
    tests++; if (done_cnt !== 1 || error !== 1'b0) begin fails++; $display("FAIL to_rerun done=%0d error=%b want 1/0", done_cnt, error); end
  endtask

  task automatic test_busy_start();
    fill_rand(); clear_obs();
    @(negedge clk); start = 1;
    repeat (10) @(negedge clk);
    start = 0;
    for (int c = 0; c < 2000 && done_cnt == 0; c++) @(negedge clk);
    repeat (3) @(negedge clk);
    tests++;
    if (issue_cnt !== NL || h_lag.size() != NL || done_cnt !== 1 || busy !== 1'b0) begin
      fails++; $display("FAIL busy_start issue=%0d results=%0d done=%0d busy=%b want %0d/%0d/1/0", issue_cnt, h_lag.size(), done_cnt, busy, NL, NL);
    end
  endtask

  task automatic test_reset_mid();
    int c;
    fill_lin(); clear_obs();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (c = 0; c < 20 && !dp_product_tready; c++) @(negedge clk);
    tests++; if (!dp_product_tready) begin fails++; $display("FAIL rstmid_wait got tready=%b want 1", dp_product_tready); end
    rst_n = 0;
    #1 tests++;
    if ({busy, done, error, lag_addr, dp_in_tvalid, dp_product_tready, res_tvalid, res_lag, res_i, res_q, peak_lag, peak_mag} !== '0) begin
      fails++; $display("FAIL rstmid_outputs busy=%b tready=%b lag=%0d want all 0", busy, dp_product_tready, lag_addr);
    end
    repeat (3) @(negedge clk);
    rst_n = 1;
    repeat (6) @(negedge clk);
    tests++; if (done_cnt !== 0 || busy !== 1'b0 || h_lag.size() != 0) begin fails++; $display("FAIL rstmid_nodone done=%0d busy=%b results=%0d want 0/0/0", done_cnt, busy, h_lag.size()); end
  endtask

  task automatic test_extreme();
    bit ok; int pl; longint pm;
    for (int k = 0; k < NL; k++) begin mod_i[k] = 24'sh800000; mod_q[k] = 24'sh800000; end
    clear_obs(); run_sweep(ok); exp_peak(NL, pl, pm);
    tests++; if (!ok || h_lag.size() != NL || h_i[0] !== 24'h800000) begin fails++; $display("FAIL ext_res done=%0d results=%0d want 1/%0d", done_cnt, h_lag.size(), NL); end
    tests++; if (int'(peak_lag) !== pl || longint'(peak_mag) !== pm) begin fails++; $display("FAIL ext_peak got %0d/%0d want %0d/%0d", peak_lag, peak_mag, pl, pm); end
  endtask

  task automatic test_random();
    bit ok; int pl; longint pm;
    for (int r = 0; r < 4; r++) begin
      fill_rand(); clear_obs(); run_sweep(ok); exp_peak(NL, pl, pm);
      tests++; if (!ok || h_lag.size() != NL) begin fails++; $display("FAIL rnd%0d_count done=%0d results=%0d", r, done_cnt, h_lag.size()); end
      for (int k = 0; k < h_lag.size() && k < NL; k++) begin
        tests++;
        if (h_lag[k] !== k || h_i[k] !== mod_i[k] || h_q[k] !== mod_q[k]) begin
          fails++; $display("FAIL rnd%0d_res%0d got %0d/%0h/%0h want %0d/%0h/%0h", r, k, h_lag[k], h_i[k], h_q[k], k, mod_i[k], mod_q[k]);
        end
      end
      tests++; if (int'(peak_lag) !== pl || longint'(peak_mag) !== pm) begin fails++; $display("FAIL rnd%0d_peak got %0d/%0d want %0d/%0d", r, peak_lag, peak_mag, pl, pm); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ties();
    test_backpressure();
    test_timeout();
    test_busy_start();
    test_reset_mid();
    test_extreme();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
